// File: rtl/usb_ctl_pkg.sv
// Shared types and constants for the EP0 control-transfer arbiter.
// Optional watchdog is enabled by defining USB_CTL_TIMEOUT_EN.
package usb_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DATA_IN  = 3'd1,
        ST_DATA_OUT = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_STALL    = 3'd4
    } ctl_state_t;

    localparam int REQ_DIR_BIT = 7;
    localparam int LEN_W       = 16;
    localparam int TIMEOUT_W   = 16;

    localparam logic [7:0] SET_ADDRESS       = 8'h05;
    localparam logic [7:0] GET_DESCRIPTOR    = 8'h06;
    localparam logic [7:0] SET_CONFIGURATION = 8'h09;

    // States in which a handler owns the transfer.
    function automatic logic is_routed(ctl_state_t s);
        return (s == ST_DATA_IN) || (s == ST_DATA_OUT) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/usb_ctl_len_limiter.sv
// wLength tracking for the IN stage: remaining-byte counter plus last-beat
// generation that merges handler last with the wLength limit.
module usb_ctl_len_limiter
    import usb_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             beat,
    input  logic             h_last,
    input  logic [LEN_W-1:0] length,
    output logic [LEN_W-1:0] remaining,
    output logic             last_beat,
    output logic             len_zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= length;
        end else if (beat && (remaining != '0)) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Handler last and the wLength limit on the same beat collapse into one last.
    assign last_beat = h_last || (remaining == LEN_W'(1));
    assign len_zero  = (length == '0);

endmodule

// File: rtl/usb_ctl_arbiter.sv
// EP0 control-transfer arbiter between the standard (h0) and vendor/class (h1)
// request handlers. Define USB_CTL_TIMEOUT_EN to add the handshake watchdog.
//
// state       | meaning
// ST_IDLE     | waiting for a ctl_xfer rise
// ST_DATA_IN  | IN bytes streamed from h[sel], truncated to wLength
// ST_DATA_OUT | OUT bytes and done routed to h[sel]
// ST_FLUSH    | IN stage complete, no further bytes; done passed through
// ST_STALL    | no handler accepted (or watchdog abort) until ctl_xfer falls
module usb_ctl_arbiter
    import usb_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ctl_xfer_type,
    input  logic [7:0]  ctl_xfer_request,
    input  logic [15:0] ctl_xfer_value,
    input  logic [15:0] ctl_xfer_index,
    input  logic [15:0] ctl_xfer_length,
    input  logic        ctl_xfer,
    output logic        ctl_xfer_accept,
    output logic        ctl_xfer_done,
    output logic        ctl_xfer_stall,
    input  logic [7:0]  ctl_xfer_data_out,
    input  logic        ctl_xfer_data_out_valid,
    output logic [7:0]  ctl_xfer_data_in,
    output logic        ctl_xfer_data_in_valid,
    output logic        ctl_xfer_data_in_last,
    input  logic        ctl_xfer_data_in_ready,
    output logic [7:0]  h0_xfer_type,
    output logic [7:0]  h0_xfer_request,
    output logic [15:0] h0_xfer_value,
    output logic [15:0] h0_xfer_index,
    output logic [15:0] h0_xfer_length,
    input  logic        h0_accept,
    output logic        h0_xfer,
    input  logic        h0_done,
    output logic [7:0]  h0_data_out,
    output logic        h0_data_out_valid,
    input  logic [7:0]  h0_data_in,
    input  logic        h0_data_in_valid,
    input  logic        h0_data_in_last,
    output logic        h0_data_in_ready,
    output logic [7:0]  h1_xfer_type,
    output logic [7:0]  h1_xfer_request,
    output logic [15:0] h1_xfer_value,
    output logic [15:0] h1_xfer_index,
    output logic [15:0] h1_xfer_length,
    input  logic        h1_accept,
    output logic        h1_xfer,
    input  logic        h1_done,
    output logic [7:0]  h1_data_out,
    output logic        h1_data_out_valid,
    input  logic [7:0]  h1_data_in,
    input  logic        h1_data_in_valid,
    input  logic        h1_data_in_last,
    output logic        h1_data_in_ready,
    output logic        timeout_err
);

    ctl_state_t       state, state_nxt;
    logic             sel;
    logic             xfer_q;
    logic             rise;
    logic             any_accept;
    logic             hs;
    logic             last_beat;
    logic             len_zero;
    logic             timeout_hit;
    logic             sel_done;
    logic             sel_in_valid;
    logic             sel_in_last;
    logic [7:0]       sel_in_data;
    logic [LEN_W-1:0] remaining;

    assign h0_xfer_type    = ctl_xfer_type;
    assign h0_xfer_request = ctl_xfer_request;
    assign h0_xfer_value   = ctl_xfer_value;
    assign h0_xfer_index   = ctl_xfer_index;
    assign h0_xfer_length  = ctl_xfer_length;
    assign h0_data_out     = ctl_xfer_data_out;
    assign h1_xfer_type    = ctl_xfer_type;
    assign h1_xfer_request = ctl_xfer_request;
    assign h1_xfer_value   = ctl_xfer_value;
    assign h1_xfer_index   = ctl_xfer_index;
    assign h1_xfer_length  = ctl_xfer_length;
    assign h1_data_out     = ctl_xfer_data_out;

    assign any_accept      = h0_accept | h1_accept;
    assign ctl_xfer_accept = any_accept;
    assign rise            = ctl_xfer & ~xfer_q;

    assign sel_done     = sel ? h1_done          : h0_done;
    assign sel_in_valid = sel ? h1_data_in_valid : h0_data_in_valid;
    assign sel_in_last  = sel ? h1_data_in_last  : h0_data_in_last;
    assign sel_in_data  = sel ? h1_data_in       : h0_data_in;

    assign hs = ctl_xfer_data_in_valid & ctl_xfer_data_in_ready;

    usb_ctl_len_limiter u_len (
        .clk       (clk),
        .rst       (rst),
        .load      ((state == ST_IDLE) && rise),
        .clear     (~ctl_xfer),
        .beat      (hs),
        .h_last    (sel_in_last),
        .length    (ctl_xfer_length),
        .remaining (remaining),
        .last_beat (last_beat),
        .len_zero  (len_zero)
    );

    // xfer_q resets high so a ctl_xfer still asserted across reset is not a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sel    <= 1'b0;
            xfer_q <= 1'b1;
        end else begin
            state  <= state_nxt;
            xfer_q <= ctl_xfer;
            if ((state == ST_IDLE) && rise && any_accept) begin
                sel <= ~h0_accept;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    if (!any_accept) begin
                        state_nxt = ST_STALL;
                    end else if (ctl_xfer_type[REQ_DIR_BIT]) begin
                        state_nxt = len_zero ? ST_FLUSH : ST_DATA_IN;
                    end else begin
                        state_nxt = ST_DATA_OUT;
                    end
                end
            end
            ST_DATA_IN: begin
                if (timeout_hit) begin
                    state_nxt = ST_STALL;
                end else if (hs && last_beat) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_DATA_OUT: begin
                if (timeout_hit) begin
                    state_nxt = ST_STALL;
                end
            end
            default: state_nxt = state;
        endcase
        if (!ctl_xfer) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        h0_xfer                = 1'b0;
        h1_xfer                = 1'b0;
        h0_data_out_valid      = 1'b0;
        h1_data_out_valid      = 1'b0;
        h0_data_in_ready       = 1'b0;
        h1_data_in_ready       = 1'b0;
        ctl_xfer_data_in       = 8'h00;
        ctl_xfer_data_in_valid = 1'b0;
        ctl_xfer_data_in_last  = 1'b0;
        ctl_xfer_stall         = (state == ST_STALL);
        ctl_xfer_done          = is_routed(state) ? sel_done : 1'b0;
        if (ctl_xfer && is_routed(state)) begin
            h0_xfer = ~sel;
            h1_xfer = sel;
            if (state == ST_DATA_IN) begin
                ctl_xfer_data_in       = sel_in_data;
                ctl_xfer_data_in_valid = sel_in_valid;
                ctl_xfer_data_in_last  = sel_in_valid & last_beat;
                h0_data_in_ready       = ~sel & ctl_xfer_data_in_ready;
                h1_data_in_ready       = sel & ctl_xfer_data_in_ready;
            end
            if (state == ST_DATA_OUT) begin
                h0_data_out_valid = ~sel & ctl_xfer_data_out_valid;
                h1_data_out_valid = sel & ctl_xfer_data_out_valid;
            end
        end
    end

`ifdef USB_CTL_TIMEOUT_EN
    // Down-counter reloaded on progress; terminal count 0 marks TIMEOUT_CYCLES idle cycles.
    localparam logic [TIMEOUT_W-1:0] WD_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 wd_run;
    logic                 wd_kick;

    assign wd_run  = ctl_xfer && ((state == ST_DATA_IN) || (state == ST_DATA_OUT));
    assign wd_kick = (state == ST_DATA_IN) ? hs : sel_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= WD_LOAD;
        end else if (!wd_run || wd_kick) begin
            wd_cnt <= WD_LOAD;
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - TIMEOUT_W'(1);
        end
    end

    assign timeout_hit = wd_run && !wd_kick && (wd_cnt == '0);
`else
    logic timeout_unused;
    assign timeout_unused = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_usb_ctl_arbiter.sv
// Self-checking bench for usb_ctl_arbiter: directed test-plan transfers, reset
// mid-transfer, optional watchdog, then randomized transfers against a stream model.
module tb_usb_ctl_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ctl_xfer_type, ctl_xfer_request;
    logic [15:0] ctl_xfer_value, ctl_xfer_index, ctl_xfer_length;
    logic        ctl_xfer, ctl_xfer_accept, ctl_xfer_done, ctl_xfer_stall;
    logic [7:0]  ctl_xfer_data_out, ctl_xfer_data_in;
    logic        ctl_xfer_data_out_valid, ctl_xfer_data_in_valid, ctl_xfer_data_in_last;
    logic        ctl_xfer_data_in_ready;
    logic [7:0]  h0_xfer_type, h0_xfer_request, h1_xfer_type, h1_xfer_request;
    logic [15:0] h0_xfer_value, h0_xfer_index, h0_xfer_length;
    logic [15:0] h1_xfer_value, h1_xfer_index, h1_xfer_length;
    logic        h0_accept, h0_xfer, h0_done, h0_data_out_valid;
    logic        h1_accept, h1_xfer, h1_done, h1_data_out_valid;
    logic [7:0]  h0_data_out, h1_data_out, h0_data_in, h1_data_in;
    logic        h0_data_in_valid, h0_data_in_last, h0_data_in_ready;
    logic        h1_data_in_valid, h1_data_in_last, h1_data_in_ready;
    logic        timeout_err;

    usb_ctl_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ctl_xfer_type(ctl_xfer_type), .ctl_xfer_request(ctl_xfer_request),
        .ctl_xfer_value(ctl_xfer_value), .ctl_xfer_index(ctl_xfer_index),
        .ctl_xfer_length(ctl_xfer_length), .ctl_xfer(ctl_xfer),
        .ctl_xfer_accept(ctl_xfer_accept), .ctl_xfer_done(ctl_xfer_done),
        .ctl_xfer_stall(ctl_xfer_stall), .ctl_xfer_data_out(ctl_xfer_data_out),
        .ctl_xfer_data_out_valid(ctl_xfer_data_out_valid), .ctl_xfer_data_in(ctl_xfer_data_in),
        .ctl_xfer_data_in_valid(ctl_xfer_data_in_valid), .ctl_xfer_data_in_last(ctl_xfer_data_in_last),
        .ctl_xfer_data_in_ready(ctl_xfer_data_in_ready),
        .h0_xfer_type(h0_xfer_type), .h0_xfer_request(h0_xfer_request),
        .h0_xfer_value(h0_xfer_value), .h0_xfer_index(h0_xfer_index),
        .h0_xfer_length(h0_xfer_length), .h0_accept(h0_accept), .h0_xfer(h0_xfer),
        .h0_done(h0_done), .h0_data_out(h0_data_out), .h0_data_out_valid(h0_data_out_valid),
        .h0_data_in(h0_data_in), .h0_data_in_valid(h0_data_in_valid),
        .h0_data_in_last(h0_data_in_last), .h0_data_in_ready(h0_data_in_ready),
        .h1_xfer_type(h1_xfer_type), .h1_xfer_request(h1_xfer_request),
        .h1_xfer_value(h1_xfer_value), .h1_xfer_index(h1_xfer_index),
        .h1_xfer_length(h1_xfer_length), .h1_accept(h1_accept), .h1_xfer(h1_xfer),
        .h1_done(h1_done), .h1_data_out(h1_data_out), .h1_data_out_valid(h1_data_out_valid),
        .h1_data_in(h1_data_in), .h1_data_in_valid(h1_data_in_valid),
        .h1_data_in_last(h1_data_in_last), .h1_data_in_ready(h1_data_in_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [7:0] descr [0:255];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ctl_xfer = 1'b0; ctl_xfer_type = 8'h00; ctl_xfer_request = 8'h00;
        ctl_xfer_value = 16'h0; ctl_xfer_index = 16'h0; ctl_xfer_length = 16'h0;
        ctl_xfer_data_out = 8'h00; ctl_xfer_data_out_valid = 1'b0; ctl_xfer_data_in_ready = 1'b0;
        h0_accept = 1'b0; h0_done = 1'b0; h0_data_in = 8'h00; h0_data_in_valid = 1'b0; h0_data_in_last = 1'b0;
        h1_accept = 1'b0; h1_done = 1'b0; h1_data_in = 8'h00; h1_data_in_valid = 1'b0; h1_data_in_last = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_h0_xfer"},  32'(h0_xfer), 0);
        chk({tag, "_h1_xfer"},  32'(h1_xfer), 0);
        chk({tag, "_h0_rdy"},   32'(h0_data_in_ready), 0);
        chk({tag, "_h1_rdy"},   32'(h1_data_in_ready), 0);
        chk({tag, "_h0_ov"},    32'(h0_data_out_valid), 0);
        chk({tag, "_h1_ov"},    32'(h1_data_out_valid), 0);
        chk({tag, "_in_valid"}, 32'(ctl_xfer_data_in_valid), 0);
        chk({tag, "_in_last"},  32'(ctl_xfer_data_in_last), 0);
        chk({tag, "_stall"},    32'(ctl_xfer_stall), 0);
        chk({tag, "_done"},     32'(ctl_xfer_done), 0);
        chk({tag, "_timeout"},  32'(timeout_err), 0);
    endtask

    task automatic start_xfer(input bit a0, input bit a1, input bit dir, input int wlen);
        @(posedge clk); #1;
        ctl_xfer_type    = {dir, 7'($urandom)};
        ctl_xfer_request = dir ? usb_ctl_pkg::GET_DESCRIPTOR : usb_ctl_pkg::SET_CONFIGURATION;
        ctl_xfer_value   = 16'($urandom);
        ctl_xfer_index   = 16'($urandom);
        ctl_xfer_length  = 16'(wlen);
        h0_accept = a0; h1_accept = a1; ctl_xfer = 1'b1;
        @(negedge clk);
        chk("rise_h0_xfer", 32'(h0_xfer), 0);
        chk("rise_h1_xfer", 32'(h1_xfer), 0);
        chk("accept_or", 32'(ctl_xfer_accept), 32'(a0 | a1));
        chk("bcast_len", 32'(h1_xfer_length), 32'(wlen));
        chk("bcast_req", 32'(h0_xfer_request), 32'(ctl_xfer_request));
    endtask

    task automatic end_xfer(input bit stalled);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("fall_stall", 32'(ctl_xfer_stall), 32'(stalled));
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet("after_fall");
    endtask

    // Model: sel is h0 if it accepts else h1; IN stream = first min(wLength, hcnt)
    // descriptor bytes, last on the final one, nothing afterwards.
    task automatic run_xfer(input bit a0, input bit a1, input bit dir,
                            input int wlen, input int hcnt, input int out_cycles);
        bit   stalled, sel_e, hv, hr, d0, d1, ov, in_data, exp_v;
        int   exp_beats, beats, idx, post;
        logic [7:0] ob;
        stalled   = !(a0 || a1);
        sel_e     = !a0;
        exp_beats = (wlen < hcnt) ? wlen : hcnt;
        for (int i = 0; i < 256; i++) descr[i] = 8'($urandom);
        start_xfer(a0, a1, dir, wlen);
        if (stalled) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                h0_done = 1'b1; h1_done = 1'b1; h0_data_in_valid = 1'b1; h1_data_in_valid = 1'b1;
                ctl_xfer_data_in_ready = 1'b1;
                @(negedge clk);
                chk("stall_on", 32'(ctl_xfer_stall), 1);
                chk("stall_done", 32'(ctl_xfer_done), 0);
                chk("stall_h0_xfer", 32'(h0_xfer), 0);
                chk("stall_h1_xfer", 32'(h1_xfer), 0);
                chk("stall_in_valid", 32'(ctl_xfer_data_in_valid), 0);
            end
        end else if (dir) begin
            beats = 0; idx = 0; post = 0;
            for (int c = 0; c < 400 && post < 3; c++) begin
                @(posedge clk); #1;
                hv = (idx < hcnt) && ($urandom_range(0, 3) != 0);
                hr = ($urandom_range(0, 3) != 0);
                d0 = 1'($urandom); d1 = 1'($urandom);
                h0_done = d0; h1_done = d1;
                ctl_xfer_data_in_ready = hr;
                if (sel_e) begin
                    h1_data_in = descr[idx]; h1_data_in_valid = hv; h1_data_in_last = (idx == hcnt - 1);
                    h0_data_in = ~descr[idx]; h0_data_in_valid = 1'($urandom); h0_data_in_last = 1'($urandom);
                end else begin
                    h0_data_in = descr[idx]; h0_data_in_valid = hv; h0_data_in_last = (idx == hcnt - 1);
                    h1_data_in = ~descr[idx]; h1_data_in_valid = 1'($urandom); h1_data_in_last = 1'($urandom);
                end
                @(negedge clk);
                in_data = (beats < exp_beats);
                exp_v   = in_data && hv;
                chk("in_valid", 32'(ctl_xfer_data_in_valid), 32'(exp_v));
                chk("sel_xfer", 32'(sel_e ? h1_xfer : h0_xfer), 1);
                chk("unsel_xfer", 32'(sel_e ? h0_xfer : h1_xfer), 0);
                chk("sel_ready", 32'(sel_e ? h1_data_in_ready : h0_data_in_ready), 32'(in_data && hr));
                chk("unsel_ready", 32'(sel_e ? h0_data_in_ready : h1_data_in_ready), 0);
                chk("done_pass", 32'(ctl_xfer_done), 32'(sel_e ? d1 : d0));
                chk("in_timeout", 32'(timeout_err), 0);
                if (exp_v) begin
                    chk("in_data", 32'(ctl_xfer_data_in), 32'(descr[idx]));
                    chk("in_last", 32'(ctl_xfer_data_in_last), 32'(beats + 1 == exp_beats));
                    if (hr) begin
                        beats++; idx++;
                    end
                end
                if (!in_data) post++;
            end
            chk("in_beats", beats, exp_beats);
        end else begin
            for (int c = 0; c < out_cycles; c++) begin
                @(posedge clk); #1;
                ob = (c == 0) ? 8'hA5 : (c == 1) ? 8'h5A : 8'($urandom);
                ov = (c < 2) ? 1'b1 : 1'($urandom);
                d0 = 1'($urandom); d1 = 1'($urandom);
                ctl_xfer_data_out = ob; ctl_xfer_data_out_valid = ov;
                h0_done = d0; h1_done = d1;
                h0_data_in_valid = 1'b1; h1_data_in_valid = 1'b1;
                @(negedge clk);
                chk("out_sel_valid", 32'(sel_e ? h1_data_out_valid : h0_data_out_valid), 32'(ov));
                chk("out_unsel_valid", 32'(sel_e ? h0_data_out_valid : h1_data_out_valid), 0);
                chk("out_data", 32'(sel_e ? h1_data_out : h0_data_out), 32'(ob));
                chk("out_sel_xfer", 32'(sel_e ? h1_xfer : h0_xfer), 1);
                chk("out_unsel_xfer", 32'(sel_e ? h0_xfer : h1_xfer), 0);
                chk("out_done", 32'(ctl_xfer_done), 32'(sel_e ? d1 : d0));
                chk("out_in_valid", 32'(ctl_xfer_data_in_valid), 0);
                chk("out_stall", 32'(ctl_xfer_stall), 0);
            end
        end
        end_xfer(stalled);
    endtask

    task automatic reset_mid_in();
        for (int i = 0; i < 256; i++) descr[i] = 8'(i);
        start_xfer(1'b1, 1'b0, 1'b1, 64);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            h0_data_in = descr[c]; h0_data_in_valid = 1'b1; ctl_xfer_data_in_ready = 1'b1;
        end
        @(negedge clk);
        chk("pre_rst_h0_xfer", 32'(h0_xfer), 1);
        @(posedge clk); #1;
        rst = 1'b1; h0_done = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst_mid");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_no_rise", 32'(h0_xfer), 0);
        end
        end_xfer(1'b0);
    endtask

`ifdef USB_CTL_TIMEOUT_EN
    task automatic timeout_in();
        start_xfer(1'b1, 1'b0, 1'b1, 64);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            h0_data_in_valid = 1'b0; ctl_xfer_data_in_ready = 1'b1;
            @(negedge clk);
            chk("to_pulse", 32'(timeout_err), 32'(k == TO));
            chk("to_stall", 32'(ctl_xfer_stall), 32'(k > TO));
        end
        end_xfer(1'b1);
    endtask
`endif

    initial begin
        int hcnt, wlen;
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");

        run_xfer(1'b1, 1'b0, 1'b1, 64, 18, 0);
        run_xfer(1'b1, 1'b0, 1'b1, 8, 18, 0);
        run_xfer(1'b1, 1'b1, 1'b1, 18, 18, 0);
        run_xfer(1'b0, 1'b1, 1'b0, 16, 0, 6);
        run_xfer(1'b0, 1'b0, 1'b1, 8, 8, 0);
        run_xfer(1'b1, 1'b0, 1'b1, 0, 18, 0);
        run_xfer(1'b0, 1'b1, 1'b1, 1, 5, 0);
        reset_mid_in();
`ifdef USB_CTL_TIMEOUT_EN
        timeout_in();
`endif

        for (int n = 0; n < 30; n++) begin
            hcnt = $urandom_range(1, 40);
            case ($urandom_range(0, 4))
                0:       wlen = 0;
                1:       wlen = 1;
                2:       wlen = hcnt;
                3:       wlen = $urandom_range(1, hcnt);
                default: wlen = $urandom_range(hcnt, 64);
            endcase
            run_xfer(1'($urandom), 1'($urandom), 1'($urandom), wlen, hcnt, $urandom_range(3, 8));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/usb_ctl_arbiter.md
# usb_ctl_arbiter

Sequencer/arbiter that shares the EP0 control-transfer port of the USB protocol engine between two request handlers. Handler 0 is the standard-request handler; handler 1 is a vendor/class handler. The block selects the accepting handler at transfer start and routes the transfer to it. It truncates IN data to wLength, generates STALL when no handler accepts, and returns to idle when the engine drops `ctl_xfer`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 65535: idle-handshake cycles before abort. Used only with `USB_CTL_TIMEOUT_EN`; 16-bit range.

Ports. Reset `rst` is synchronous, active-high; clock `clk`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `ctl_xfer_type`/`_request`/`_value`/`_index`/`_length` in 8/8/16/16/16: setup fields from engine; stable while `ctl_xfer` high. Broadcast unmodified to `h0_*`/`h1_*`.
- `ctl_xfer` in 1: transfer active (level).
- `ctl_xfer_accept` out 1: `h0_accept | h1_accept`, combinational.
- `ctl_xfer_done` out 1: selected handler's `done`; 0 in STALL/IDLE.
- `ctl_xfer_stall` out 1: request rejected or aborted.
- `ctl_xfer_data_out`, `_valid` in 8/1: OUT-stage bytes.
- `ctl_xfer_data_in`, `_valid`, `_last` out 8/1/1; `ctl_xfer_data_in_ready` in 1: IN-stage stream.
- `hN_accept` in 1, `hN_xfer` out 1, `hN_done` in 1, `hN_data_out_valid` out 1, `hN_data_in[7:0]`/`_valid`/`_last` in, `hN_data_in_ready` out, for N = 0, 1. `ctl_xfer_data_out` is broadcast to both handlers.
- `timeout_err` out 1: one-cycle pulse on watchdog abort. Tied 0 without the macro.

## Operation
States are IDLE, DATA_IN, DATA_OUT, FLUSH and STALL.

- **IDLE**, on `ctl_xfer` rising:
  - Latch `sel` = 0 if `h0_accept`, else 1 if `h1_accept`. Handler 0 has priority.
  - Load `remaining` = `ctl_xfer_length`.
  - No accept → STALL.
  - `ctl_xfer_type[7]`=1 and length≠0 → DATA_IN.
  - `ctl_xfer_type[7]`=1 and length=0 → FLUSH.
  - `ctl_xfer_type[7]`=0 → DATA_OUT.
- **Handler gating:** `hN_xfer` = `ctl_xfer` & (state≠IDLE, ≠STALL) & `sel`==N. The unselected handler sees `hN_xfer`=0, `hN_data_out_valid`=0 and `hN_data_in_ready`=0.
- **DATA_IN:**
  - Upstream `data_in`/`valid` come from `h[sel]`.
  - `data_in_last` = `h[sel]_last` | (`remaining`==1).
  - `h[sel]_data_in_ready` = `ctl_xfer_data_in_ready`.
  - On each valid&ready: `remaining` −1 (16-bit, no wrap below 0).
  - Handshake with last → FLUSH.
- **FLUSH:** upstream `valid`=0. Handler ready is held 0, so surplus descriptor bytes are never transferred.
- **DATA_OUT:** `h[sel]_data_out_valid` = `ctl_xfer_data_out_valid`; `done` is passed through.
- **`ctl_xfer` falling:** any state → IDLE, `sel` kept, `remaining` cleared. A new rise is honoured no earlier than the cycle after IDLE is reached.
- **STALL:** `ctl_xfer_stall`=1 until `ctl_xfer` falls.
- Handler `last` and `remaining`==1 on the same beat produce a single `last`.

## Timing
- Reset values:
  - State IDLE, `sel`=0, `remaining`=0.
  - All `hN_xfer`, `hN_data_out_valid`, `hN_data_in_ready` = 0.
  - `ctl_xfer_data_in_valid`/`_last`/`_stall`/`_done` and `timeout_err` = 0.
- Rise to routing: `hN_xfer` asserts the cycle after `ctl_xfer` rises, i.e. one cycle of latency. IN data is combinational from the handler once in DATA_IN (zero added latency per beat).
- `ctl_xfer_stall` asserts the cycle after the rise and stays high through the fall cycle.
- Reset mid-transfer: all outputs return to reset values the next cycle. A still-high `ctl_xfer` is not treated as a rise, so the block waits for a low before the next transfer.

## Configuration
- `USB_CTL_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles in DATA_IN without a valid&ready handshake, and cycles in DATA_OUT without `h[sel]_done`.
  - The count resets on each handshake.
  - Reaching `TIMEOUT_CYCLES` → STALL and a one-cycle `timeout_err` pulse.
- Undefined: no counter is present, `timeout_err`=0, and STALL is entered only on no-accept.

## Structure
- Shared package `usb_ctl_pkg` holds:
  - State enum.
  - Direction bit index (`REQ_DIR_BIT`=7).
  - Standard request codes (GET_DESCRIPTOR 8'h06, SET_ADDRESS 8'h05, SET_CONFIGURATION 8'h09).
  - Timeout width.
- Sub-module `usb_ctl_len_limiter`: the `remaining` counter plus last/flush generation.

## Test plan
- Std-handler device-descriptor request: h0 accepts, wLength=64, handler supplies 18 bytes → 18 beats, `last` on beat 18, `h1_xfer` never asserted.
- wLength=8 against an 18-byte descriptor → exactly 8 beats, `last` on beat 8, then FLUSH with `valid`=0 until the fall.
- Both accept → h0 selected. Only h1 accepts → `h1_xfer`=1 and OUT bytes 0xA5,0x5A reach only h1.
- Neither accepts → `ctl_xfer_stall`=1 from cycle 2 until the fall, `done`=0.
- IN request with wLength=0 → no data beats, FLUSH, `done` passed through.
- Macro on, `TIMEOUT_CYCLES`=16, handler never valid → `timeout_err` pulse at cycle 16 of DATA_IN, then STALL. Also `rst` mid-DATA_IN → outputs at reset values next cycle.
